ones_stream_gen: RTL and testbench
==================================

# ones_stream_gen

Transmit-side counterpart of the 127-bit ones counter. Accepts a population count over a valid/ready handshake and serialises a 127-bit frame containing exactly that many ones, one bit per accepted beat. It also presents the assembled word in parallel at frame end, so a downstream ones counter can close the loop. It sits between the control logic that chooses a weight and any serial consumer or checker of weighted words.

## Interface
- `WIDTH`, 127: frame length in bits.
- `CNT_W`, 7: count width. Must satisfy 2^CNT_W − 1 ≥ WIDTH.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_valid` in 1: count request valid.
- `s_ready` out 1: block idle, can accept a count.
- `s_count` in CNT_W: requested number of ones.
- `m_valid` out 1: serial bit valid.
- `m_ready` in 1: consumer accepts bit.
- `m_bit` out 1: current frame bit; index 0 first.
- `m_last` out 1: high with bit index WIDTH−1.
- `word_out` out WIDTH: assembled frame, bit n = serial bit n.
- `word_valid` out 1: one-cycle pulse, `word_out` complete.
- `cnt_err` out 1: one-cycle pulse, `s_count` > WIDTH was clamped.

## Operation
- FSM states:
  - IDLE: `s_ready`=1. `s_valid`&`s_ready` latches `cnt`=min(`s_count`,WIDTH), clears `idx`, `acc` and `word_out`, pulses `cnt_err` if clamped, then goes to SEND.
  - SEND: `m_valid`=1. On `m_valid`&`m_ready`, `word_out[idx]`←`m_bit`, `idx`++. A handshake at `idx`=WIDTH−1 goes to DONE.
  - DONE: `word_valid`=1 for one cycle, then go to IDLE.
- Thermometer bit rule: `m_bit` = (`idx` < `cnt`).
- Frame length is always WIDTH beats. Popcount of `word_out` equals `cnt` in both modes.
- `m_bit` and `m_last` are functions of registered state only. They are stable while `m_valid`&!`m_ready`.
- `word_out` holds its value from DONE until the next accept.
- `idx` is ⌈log2 WIDTH⌉ bits wide. `acc` is CNT_W+1 bits wide. No wrap-around is possible: `idx` stops at WIDTH−1.

## Timing
- Reset values: `s_ready`=1 (state IDLE); `m_valid`, `m_bit`, `m_last`, `word_valid`, `cnt_err` = 0; `word_out`=0; internal `idx`, `acc`, `cnt` = 0.
- Accept at edge k puts the first `m_valid` high in cycle k+1. There is no combinational path from `s_valid` to `m_valid`.
- `cnt_err` is asserted in cycle k+1.
- With `m_ready` held at 1, the last beat is in cycle k+WIDTH, `word_valid` is in cycle k+WIDTH+1, and `s_ready` returns in cycle k+WIDTH+2. Peak rate is one frame per WIDTH+2 cycles.
- `s_ready` is 0 during SEND and DONE. A `s_valid` in those states is ignored and must stay held by the source.
- Reset asserted mid-frame aborts immediately to the reset values. No `m_last` or `word_valid` is produced for the aborted frame.

## Configuration
- `ONES_STREAM_SPREAD_EN` defined: ones are distributed evenly (Bresenham).
  - `m_bit` = (`acc`+`cnt` ≥ WIDTH).
  - On each handshake, `acc` ← `acc`+`cnt`−(`m_bit` ? WIDTH : 0).
  - `acc` is cleared on accept.
- Undefined: thermometer rule only. The `acc` register is not built.
- Handshake and timing are identical in both modes.

## Structure
- Package `ones_pkg` holds:
  - the `WIDTH` and `CNT_W` defaults;
  - the state enum {IDLE, SEND, DONE};
  - the derived `IDX_W` constant.
- One sub-module, `ones_bit_sel`. It is combinational: it takes `idx`, `cnt` and `acc` and produces `m_bit` and `acc_next`, with the mode chosen by the macro. The top level keeps the FSM, counters and word register.

## Test plan
- `s_count`=0, `m_ready`=1 → 127 beats with `m_bit`=0, `m_last` on beat 127, `word_out`=0, one `word_valid` pulse.
- `s_count`=127 → all 127 bits 1, `word_out`=all ones, `s_ready` back 129 cycles after accept.
- `s_count`=5, thermometer build → bits 0–4 are 1, `word_out`=0x1F; popcount through a ones counter reads 5.
- `s_count`=64 with `m_ready` toggling 1,0,1,0 → `m_bit` and `m_last` stable during stalls, exactly 127 handshakes, 64 ones.
- `ONES_STREAM_SPREAD_EN`, `s_count`=1 → the only 1 is at bit 126; `s_count`=64 → no two adjacent zeros in the frame, popcount 64.
- `CNT_W`=8, `s_count`=200 → `cnt_err` pulse, all-ones frame. Then `rst_n` low at beat 40 of a new frame → outputs at reset values, no `word_valid`; the next request completes normally.

Source files
------------

// File: rtl/ones_pkg.sv
// Shared constants and state encoding for the weighted-frame transmitter.
package ones_pkg;

    localparam int WIDTH = 127;
    localparam int CNT_W = 7;

    function automatic int idx_bits(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int IDX_W = idx_bits(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

endpackage

// File: rtl/ones_bit_sel.sv
// Per-beat bit selection: thermometer by default, Bresenham spread when
// ONES_STREAM_SPREAD_EN is defined.
module ones_bit_sel #(
    parameter int WIDTH = 127,
    parameter int CNT_W = 7,
    parameter int IDX_W = 7
) (
`ifdef ONES_STREAM_SPREAD_EN
    input  logic [CNT_W:0]   acc,
    output logic [CNT_W:0]   acc_next,
`else
    input  logic [IDX_W-1:0] idx,
`endif
    input  logic [CNT_W-1:0] cnt,
    output logic             m_bit
);

`ifdef ONES_STREAM_SPREAD_EN
    localparam logic [CNT_W:0] W_ACC = (CNT_W + 1)'(WIDTH);

    logic [CNT_W:0] sum;

    // acc stays below WIDTH, so acc+cnt never overflows CNT_W+1 bits
    always_comb begin
        sum      = acc + {1'b0, cnt};
        m_bit    = (sum >= W_ACC);
        acc_next = m_bit ? (sum - W_ACC) : sum;
    end
`else
    always_comb begin
        m_bit = (32'(idx) < 32'(cnt));
    end
`endif

endmodule

// File: rtl/ones_stream_gen.sv
// Serialises a WIDTH-bit frame holding s_count ones, one bit per beat.
// ONES_STREAM_SPREAD_EN selects evenly spread ones instead of a thermometer.
module ones_stream_gen #(
    parameter int WIDTH = ones_pkg::WIDTH,
    parameter int CNT_W = ones_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [CNT_W-1:0] s_count,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_bit,
    output logic             m_last,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             cnt_err
);

    import ones_pkg::*;

    localparam int               IW   = idx_bits(WIDTH);
    localparam logic [IW-1:0]    LAST = IW'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CMAX = CNT_W'(WIDTH);

    state_t           state;
    state_t           state_nx;
    logic [IW-1:0]    idx;
    logic [CNT_W-1:0] cnt;
    logic             bit_sel;
    logic             accept;
    logic             beat;
    logic             over;
    logic             at_last;

    assign accept  = s_valid && s_ready;
    assign beat    = m_valid && m_ready;
    assign over    = (32'(s_count) > WIDTH);
    assign at_last = (idx == LAST);

`ifdef ONES_STREAM_SPREAD_EN
    logic [CNT_W:0] acc;
    logic [CNT_W:0] acc_next;

    ones_bit_sel #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W),
        .IDX_W (IW)
    ) u_bit_sel (
        .acc      (acc),
        .acc_next (acc_next),
        .cnt      (cnt),
        .m_bit    (bit_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (accept) begin
            acc <= '0;
        end else if (beat) begin
            acc <= acc_next;
        end
    end
`else
    ones_bit_sel #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W),
        .IDX_W (IW)
    ) u_bit_sel (
        .idx   (idx),
        .cnt   (cnt),
        .m_bit (bit_sel)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        word_valid = 1'b0;
        unique case (state)
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid) state_nx = SEND;
            end
            SEND: begin
                m_valid = 1'b1;
                if (m_ready && at_last) state_nx = DONE;
            end
            DONE: begin
                word_valid = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Serial outputs depend only on registered state, so stalls keep them stable
    assign m_bit  = m_valid && bit_sel;
    assign m_last = m_valid && at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            cnt      <= '0;
            word_out <= '0;
            cnt_err  <= 1'b0;
        end else begin
            cnt_err <= 1'b0;
            if (accept) begin
                cnt      <= over ? CMAX : s_count;
                cnt_err  <= over;
                idx      <= '0;
                word_out <= '0;
            end else if (beat) begin
                word_out[idx] <= bit_sel;
                if (!at_last) idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ones_stream_gen.sv
// Scoreboard bench for ones_stream_gen: driver queues expected frames,
// a monitor checks serial beats, word_out and cnt_err as they appear.
module tb_ones_stream_gen;

    localparam int W  = 127;
    localparam int CW = 8;

    typedef struct {
        logic [W-1:0] word;
        int           ones;
        bit           err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [CW-1:0] s_count;
    logic          m_valid;
    logic          m_ready;
    logic          m_bit;
    logic          m_last;
    logic [W-1:0]  word_out;
    logic          word_valid;
    logic          cnt_err;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   wv_count = 0;
    int   err_count = 0;
    bit   toggle = 1'b0;

    ones_stream_gen #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_count    (s_count),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_bit      (m_bit),
        .m_last     (m_last),
        .word_out   (word_out),
        .word_valid (word_valid),
        .cnt_err    (cnt_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timeout", name);
    endtask

    function automatic logic [W-1:0] spread(input int n);
        int acc = 0;
        logic [W-1:0] w = '0;
        for (int i = 0; i < W; i++) begin
            if (acc + n >= W) begin
                w[i] = 1'b1;
                acc  = acc + n - W;
            end else begin
                acc = acc + n;
            end
        end
        return w;
    endfunction

    // consumer: always ready, or alternating 1,0,1,0 when toggle is set
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = toggle ? ~m_ready : 1'b1;
        end
    end

    // monitor
    initial begin
        logic [W-1:0] got;
        int  beat_i;
        bit  pv, pr, pb, pl;
        got = '0;
        beat_i = 0;
        pv = 0; pr = 0; pb = 0; pl = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                got = '0;
                beat_i = 0;
                pv = 0;
                pr = 0;
                continue;
            end
            if (pv && !pr && m_valid) begin
                chk("stall_bit", m_bit, pb);
                chk("stall_last", m_last, pl);
            end
            if (cnt_err) err_count++;
            if (m_valid && !pv) begin
                if (exp_q.size() == 0) timeout("frame_without_request");
                else chk("cnt_err", cnt_err, exp_q[0].err);
            end
            if (m_valid && m_ready) begin
                chk("m_last", m_last, beat_i == W - 1);
                if (beat_i < W) got[beat_i] = m_bit;
                beat_i++;
                if (m_last) begin
                    chk("beats", beat_i, W);
                    if (exp_q.size() > 0) chk("frame_bits", got, exp_q[0].word);
                end
            end
            if (word_valid) begin
                wv_count++;
                if (exp_q.size() == 0) begin
                    timeout("word_valid_unexpected");
                end else begin
                    chk("word_out", word_out, exp_q[0].word);
                    chk("popcount", $countones(word_out), exp_q[0].ones);
`ifdef ONES_STREAM_SPREAD_EN
                    if (exp_q[0].ones == 64)
                        chk("no_adjacent_zeros", (~word_out) & ((~word_out) >> 1), '0);
`endif
                    void'(exp_q.pop_front());
                end
                got = '0;
                beat_i = 0;
            end
            pv = m_valid;
            pr = m_ready;
            pb = m_bit;
            pl = m_last;
        end
    end

    task automatic send(input int n, input logic [W-1:0] w, input bit e);
        exp_t x;
        int k;
        s_count = CW'(n);
        s_valid = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!s_ready && k < 400);
        if (!s_ready) timeout("s_ready_wait");
        @(posedge clk);
        x.word = w;
        x.ones = (n > W) ? W : n;
        x.err  = e;
        exp_q.push_back(x);
        #1;
        s_valid = 1'b0;
        s_count = '0;
    endtask

    task automatic wait_idle();
        int k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!s_ready && k < 400);
        if (!s_ready) timeout("idle_wait");
    endtask

    task automatic chk_reset_vals();
        chk("rst_s_ready", s_ready, 1'b1);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_bit", m_bit, 1'b0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_word_valid", word_valid, 1'b0);
        chk("rst_cnt_err", cnt_err, 1'b0);
        chk("rst_word_out", word_out, '0);
    endtask

    initial begin
        logic [W-1:0] all1, w1, w3, w5, w64;
        int n, wv_at, rdy_at, b;
        all1 = '1;
`ifdef ONES_STREAM_SPREAD_EN
        w1  = '0;
        w1[W-1] = 1'b1;
        w3  = spread(3);
        w5  = spread(5);
        w64 = spread(64);
`else
        w1  = 127'h1;
        w3  = 127'h7;
        w5  = 127'h1F;
        w64 = {63'b0, {64{1'b1}}};
`endif
        rst_n = 1'b0;
        s_valid = 1'b0;
        s_count = '0;
        #12;
        chk_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(0, '0, 0);
        wait_idle();

        send(127, all1, 0);
        chk("first_m_valid", m_valid, 1'b1);
        wv_at = -1;
        rdy_at = -1;
        n = 0;
        while (rdy_at < 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (word_valid) wv_at = n;
            if (s_ready) rdy_at = n;
        end
        chk("word_valid_latency", wv_at, 127);
        chk("s_ready_latency", rdy_at, 128);

        send(5, w5, 0);
        wait_idle();

        toggle = 1'b1;
        send(64, w64, 0);
        wait_idle();
        toggle = 1'b0;

        send(1, w1, 0);
        wait_idle();

        send(200, all1, 1);
        wait_idle();

        // abort a frame partway through with an asynchronous reset
        send(10, '0, 0);
        b = 0;
        n = 0;
        while (b < 40 && n < 400) begin
            @(negedge clk);
            n++;
            if (m_valid && m_ready) b++;
        end
        if (b < 40) timeout("abort_beats");
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(3, w3, 0);
        wait_idle();

        n = 0;
        while (exp_q.size() > 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() > 0) timeout("scoreboard_drain");
        repeat (3) @(posedge clk);
        chk("word_valid_pulses", wv_count, 7);
        chk("cnt_err_pulses", err_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
